// File: rtl/sbox_share_arbiter.sv
// sbox_share_arbiter
//   Time-shares one 128-bit SubBytes array (16 AES S-boxes) between the cipher
//   round datapath (rnd, 128-bit states) and key expansion (key, 32-bit SubWord
//   operands). Fixed priority favours rnd; key preempts once it has waited
//   MAX_WAIT cycles. A single registered result buffer gives 1-cycle latency and
//   supports same-cycle drain-and-refill for full throughput.
//
// Ports
//   clk, rst                     clock, synchronous active-high reset
//   rnd_req_valid/ready/data     round request (128-bit state)
//   rnd_rsp_valid/ready/data     round response, SubBytes(state)
//   key_req_valid/ready/data     key request (32-bit word)
//   key_rsp_valid/ready/data     key response, SubWord(word)
//   busy                         result buffer occupied
module sbox_share_arbiter #(
  parameter int unsigned MAX_WAIT = 3,  // 1..15
  parameter int unsigned KEY_LANE = 0   // 0..3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         rnd_req_valid,
  output logic         rnd_req_ready,
  input  logic [127:0] rnd_req_data,
  output logic         rnd_rsp_valid,
  input  logic         rnd_rsp_ready,
  output logic [127:0] rnd_rsp_data,
  input  logic         key_req_valid,
  output logic         key_req_ready,
  input  logic [31:0]  key_req_data,
  output logic         key_rsp_valid,
  input  logic         key_rsp_ready,
  output logic [31:0]  key_rsp_data,
  output logic         busy
);

  // AES S-box. The first listed byte lands at index 255, so entry x lives at
  // index 255-x, which for an 8-bit x is simply ~x.
  localparam logic [255:0][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [3:0] WaitMax    = 4'hf;
  localparam logic [3:0] WaitThresh = 4'(MAX_WAIT);

  logic         buf_valid_q, buf_valid_d;
  logic         owner_q, owner_d;        // 0 = rnd, 1 = key
  logic [127:0] buf_data_q, buf_data_d;
  logic [3:0]   wait_cnt_q, wait_cnt_d;

  logic         force_key;
  logic         grant_rnd, grant_key;
  logic         owner_ready;
  logic         can_accept;
  logic         accept;
  logic [127:0] sbox_in;
  logic [127:0] sbox_out;

  // Arbitration and readiness.
  always_comb begin
    force_key   = key_req_valid && (wait_cnt_q >= WaitThresh);
    grant_key   = force_key || (!rnd_req_valid && key_req_valid);
    grant_rnd   = !force_key && rnd_req_valid;
    owner_ready = owner_q ? key_rsp_ready : rnd_rsp_ready;
    // Nothing is accepted while reset is held.
    can_accept  = !rst && (!buf_valid_q || owner_ready);
    rnd_req_ready = can_accept && grant_rnd;
    key_req_ready = can_accept && grant_key;
    accept        = rnd_req_ready || key_req_ready;
  end

  // S-box input mux: key word sits alone in its lane, other lanes zero.
  always_comb begin
    sbox_in = rnd_req_data;
    if (grant_key) begin
      sbox_in = '0;
      sbox_in[32*KEY_LANE +: 32] = key_req_data;
    end
  end

  for (genvar i = 0; i < 16; i++) begin : g_sbox
    logic [7:0] idx;
    assign idx = ~sbox_in[8*i +: 8];
    assign sbox_out[8*i +: 8] = SBOX[idx];
  end

  // Buffer and starvation counter next-state.
  always_comb begin
    buf_valid_d = buf_valid_q;
    owner_d     = owner_q;
    buf_data_d  = buf_data_q;
    if (accept) begin
      buf_valid_d = 1'b1;
      owner_d     = grant_key;
      buf_data_d  = sbox_out;
    end else if (buf_valid_q && owner_ready) begin
      buf_valid_d = 1'b0;
    end

    if (!key_req_valid || key_req_ready) begin
      wait_cnt_d = '0;
    end else if (wait_cnt_q != WaitMax) begin
      wait_cnt_d = wait_cnt_q + 4'd1;
    end else begin
      wait_cnt_d = wait_cnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      buf_valid_q <= 1'b0;
      owner_q     <= 1'b0;
      buf_data_q  <= '0;
      wait_cnt_q  <= '0;
    end else begin
      buf_valid_q <= buf_valid_d;
      owner_q     <= owner_d;
      buf_data_q  <= buf_data_d;
      wait_cnt_q  <= wait_cnt_d;
    end
  end

  always_comb begin
    rnd_rsp_valid = buf_valid_q && !owner_q;
    key_rsp_valid = buf_valid_q && owner_q;
    rnd_rsp_data  = buf_data_q;
    key_rsp_data  = buf_data_q[32*KEY_LANE +: 32];
    busy          = buf_valid_q;
  end

endmodule

// File: tb/tb_sbox_share_arbiter.sv
// Directed bench for sbox_share_arbiter: a lane-0 and a lane-3 instance share
// all inputs; a cycle-by-cycle vector table plus hand-written reset sequences.
module tb_sbox_share_arbiter;

  logic         clk;
  logic         rst;
  logic         rnd_req_valid, key_req_valid;
  logic [127:0] rnd_req_data;
  logic [31:0]  key_req_data;
  logic         rnd_rsp_ready, key_rsp_ready;

  logic         rnd_req_ready, key_req_ready, rnd_rsp_valid, key_rsp_valid, busy;
  logic [127:0] rnd_rsp_data;
  logic [31:0]  key_rsp_data;

  logic         rnd_req_ready_3, key_req_ready_3, rnd_rsp_valid_3, key_rsp_valid_3, busy_3;
  logic [127:0] rnd_rsp_data_3;
  logic [31:0]  key_rsp_data_3;

  int errors = 0;
  int checks = 0;

  sbox_share_arbiter #(.MAX_WAIT(3), .KEY_LANE(0)) dut (
    .clk          (clk),
    .rst          (rst),
    .rnd_req_valid(rnd_req_valid),
    .rnd_req_ready(rnd_req_ready),
    .rnd_req_data (rnd_req_data),
    .rnd_rsp_valid(rnd_rsp_valid),
    .rnd_rsp_ready(rnd_rsp_ready),
    .rnd_rsp_data (rnd_rsp_data),
    .key_req_valid(key_req_valid),
    .key_req_ready(key_req_ready),
    .key_req_data (key_req_data),
    .key_rsp_valid(key_rsp_valid),
    .key_rsp_ready(key_rsp_ready),
    .key_rsp_data (key_rsp_data),
    .busy         (busy)
  );

  sbox_share_arbiter #(.MAX_WAIT(3), .KEY_LANE(3)) dut3 (
    .clk          (clk),
    .rst          (rst),
    .rnd_req_valid(rnd_req_valid),
    .rnd_req_ready(rnd_req_ready_3),
    .rnd_req_data (rnd_req_data),
    .rnd_rsp_valid(rnd_rsp_valid_3),
    .rnd_rsp_ready(rnd_rsp_ready),
    .rnd_rsp_data (rnd_rsp_data_3),
    .key_req_valid(key_req_valid),
    .key_req_ready(key_req_ready_3),
    .key_req_data (key_req_data),
    .key_rsp_valid(key_rsp_valid_3),
    .key_rsp_ready(key_rsp_ready),
    .key_rsp_data (key_rsp_data_3),
    .busy         (busy_3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         rv;
    logic [127:0] rd;
    logic         kv;
    logic [31:0]  kd;
    logic         rr;
    logic         kr;
    logic         e_rrdy;
    logic         e_krdy;
    logic         e_rv;
    logic         e_kv;
    logic [127:0] e_rdata;
    logic [31:0]  e_kdata;
  } vec_t;

  vec_t vq[$];

  localparam logic [127:0] A   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] SA  = 128'h638293c31bfc33f5c4eeacea4bc12816;
  localparam logic [127:0] Z   = 128'h0;
  localparam logic [127:0] SZ  = {16{8'h63}};
  localparam logic [127:0] F   = {16{8'hff}};
  localparam logic [127:0] SF  = {16{8'h16}};
  localparam logic [31:0]  K   = 32'hcf4f3c09;
  localparam logic [31:0]  SK  = 32'h8a84eb01;
  localparam logic [31:0]  K2  = 32'h11223344;
  localparam logic [31:0]  SK2 = 32'h8293c31b;

  task automatic add(input logic rv, input logic [127:0] rd, input logic kv,
                     input logic [31:0] kd, input logic rr, input logic kr,
                     input logic e_rrdy, input logic e_krdy, input logic e_rv,
                     input logic e_kv, input logic [127:0] e_rdata,
                     input logic [31:0] e_kdata);
    vec_t v;
    v.rv = rv; v.rd = rd; v.kv = kv; v.kd = kd; v.rr = rr; v.kr = kr;
    v.e_rrdy = e_rrdy; v.e_krdy = e_krdy; v.e_rv = e_rv; v.e_kv = e_kv;
    v.e_rdata = e_rdata; v.e_kdata = e_kdata;
    vq.push_back(v);
  endtask

  task automatic chk(input string name, input int row, input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (step %0d): got %h, expected %h", name, row, act, exp);
    end
  endtask

  task automatic check_idle(input string tag, input int row);
    chk({tag, " rnd_req_ready"}, row, 128'(rnd_req_ready), 128'(1'b0));
    chk({tag, " key_req_ready"}, row, 128'(key_req_ready), 128'(1'b0));
    chk({tag, " rnd_rsp_valid"}, row, 128'(rnd_rsp_valid), 128'(1'b0));
    chk({tag, " key_rsp_valid"}, row, 128'(key_rsp_valid), 128'(1'b0));
    chk({tag, " key_rsp_valid lane3"}, row, 128'(key_rsp_valid_3), 128'(1'b0));
    chk({tag, " busy"}, row, 128'(busy), 128'(1'b0));
  endtask

  initial begin
    // Reset held two cycles with both requests valid.
    rst = 1'b1;
    rnd_req_valid = 1'b1; rnd_req_data = A;
    key_req_valid = 1'b1; key_req_data = K;
    rnd_rsp_ready = 1'b1; key_rsp_ready = 1'b1;
    @(negedge clk); #1;
    check_idle("reset", 0);
    @(negedge clk); #1;
    check_idle("reset", 1);

    //   rv rd kv kd  rr kr | rrdy krdy rv kv rdata kdata
    add(1, A, 1, K,  1, 1,   1, 0, 0, 0, Z,  0);   // 0 first accept after reset
    add(0, Z, 1, K,  1, 1,   0, 1, 1, 0, SA, 0);   // 1 drain rnd, refill key
    add(0, Z, 0, 0,  1, 1,   0, 0, 0, 1, Z,  SK);  // 2 key result
    add(0, Z, 0, 0,  1, 1,   0, 0, 0, 0, Z,  0);   // 3 idle
    add(1, A, 1, K,  1, 1,   1, 0, 0, 0, Z,  0);   // 4 both valid, rnd wins
    add(1, Z, 1, K,  1, 1,   1, 0, 1, 0, SA, 0);   // 5
    add(1, F, 1, K,  1, 1,   1, 0, 1, 0, SZ, 0);   // 6
    add(1, A, 1, K,  1, 1,   0, 1, 1, 0, SF, 0);   // 7 key forced
    add(1, A, 1, K,  1, 1,   1, 0, 0, 1, Z,  SK);  // 8 counter cleared, rnd resumes
    add(0, Z, 1, K2, 0, 1,   0, 0, 1, 0, SA, 0);   // 9 backpressure
    add(0, Z, 1, K2, 0, 1,   0, 0, 1, 0, SA, 0);   // 10
    add(0, Z, 1, K2, 0, 1,   0, 0, 1, 0, SA, 0);   // 11
    add(0, Z, 1, K2, 0, 1,   0, 0, 1, 0, SA, 0);   // 12
    add(0, Z, 1, K2, 0, 1,   0, 0, 1, 0, SA, 0);   // 13
    add(0, Z, 1, K2, 1, 1,   0, 1, 1, 0, SA, 0);   // 14 drain + key accept
    add(0, Z, 0, 0,  1, 0,   0, 0, 0, 1, Z,  SK2); // 15 key result held
    add(0, Z, 0, 0,  1, 0,   0, 0, 0, 1, Z,  SK2); // 16 still held

    foreach (vq[i]) begin
      @(negedge clk);
      rst = 1'b0;
      rnd_req_valid = vq[i].rv; rnd_req_data = vq[i].rd;
      key_req_valid = vq[i].kv; key_req_data = vq[i].kd;
      rnd_rsp_ready = vq[i].rr; key_rsp_ready = vq[i].kr;
      #1;
      chk("rnd_req_ready", i, 128'(rnd_req_ready), 128'(vq[i].e_rrdy));
      chk("key_req_ready", i, 128'(key_req_ready), 128'(vq[i].e_krdy));
      chk("rnd_rsp_valid", i, 128'(rnd_rsp_valid), 128'(vq[i].e_rv));
      chk("key_rsp_valid", i, 128'(key_rsp_valid), 128'(vq[i].e_kv));
      chk("key_rsp_valid lane3", i, 128'(key_rsp_valid_3), 128'(vq[i].e_kv));
      chk("busy", i, 128'(busy), 128'(vq[i].e_rv | vq[i].e_kv));
      if (vq[i].e_rv) begin
        chk("rnd_rsp_data", i, rnd_rsp_data, vq[i].e_rdata);
        chk("rnd_rsp_data lane3", i, rnd_rsp_data_3, vq[i].e_rdata);
      end
      if (vq[i].e_kv) begin
        chk("key_rsp_data", i, 128'(key_rsp_data), 128'(vq[i].e_kdata));
        chk("key_rsp_data lane3", i, 128'(key_rsp_data_3), 128'(vq[i].e_kdata));
      end
    end

    // Reset while the key result is still pending.
    @(negedge clk);
    rst = 1'b1;
    key_rsp_ready = 1'b0;
    #1;
    chk("key pending before reset", 100, 128'(key_rsp_valid), 128'(1'b1));
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_idle("after mid reset", 101);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      key_rsp_ready = 1'b1;
      #1;
      check_idle("no stale rsp", 102 + c);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sbox_share_arbiter.md
Name: sbox_share_arbiter

Overview:
- Time-shares one `subBytes` instance (16 S-boxes, 128-bit) between two requesters.
- Requester "rnd" is the cipher round datapath and sends 128-bit states.
- Requester "key" is key expansion and sends 32-bit SubWord operands.
- Fixed-priority arbitration favours rnd, with a starvation guard for key. A registered result buffer with per-requester valid/ready response channels gives 1-cycle latency and full backpressure.

Parameters:
- MAX_WAIT, 3: number of cycles key may wait while valid before it preempts rnd. Legal range 1..15.
- KEY_LANE, 0: 32-bit lane of the 128-bit S-box input that carries the key word. Legal range 0..3; lane k is bits [32k+31:32k].

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- rnd_req_valid  in  1  round request valid.
- rnd_req_ready  out  1  round request accepted this cycle.
- rnd_req_data  in  128  state to substitute.
- rnd_rsp_valid  out  1  round result valid.
- rnd_rsp_ready  in  1  round result consumed.
- rnd_rsp_data  out  128  SubBytes(state).
- key_req_valid  in  1  key request valid.
- key_req_ready  out  1  key request accepted this cycle.
- key_req_data  in  32  word to substitute.
- key_rsp_valid  out  1  key result valid.
- key_rsp_ready  in  1  key result consumed.
- key_rsp_data  out  32  SubWord(word).
- busy  out  1  result buffer occupied.

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high. While rst=1 at a rising edge, all state clears:
  - buf_valid=0, owner=0, wait_cnt=0.
  - rnd_rsp_valid=0, key_rsp_valid=0, busy=0.
  - rsp_data registers = 0.
- Reset mid-operation: a buffered, undelivered result is dropped and no response is issued. Requests held during reset are not accepted until the first cycle after rst deasserts.
- State: buf_valid, owner (0=rnd, 1=key), buf_data[127:0], wait_cnt (4-bit, saturating).
- can_accept = !buf_valid OR (buf_valid AND the owner's rsp_ready=1). The second term allows same-cycle drain-and-refill, so back-to-back accepts sustain 1 result per cycle.
- force_key = key_req_valid AND (wait_cnt >= MAX_WAIT).
- Grant, evaluated combinationally each cycle:
  - If force_key, grant key.
  - Else if rnd_req_valid, grant rnd.
  - Else if key_req_valid, grant key.
  - Else no grant.
- Readiness: rnd_req_ready = can_accept AND grant==rnd. key_req_ready = can_accept AND grant==key. A ready may depend on both valids; a ready never rises without its own valid.
- S-box input, from the granted requester:
  - rnd: rnd_req_data.
  - key: key_req_data placed in lane KEY_LANE, all other lanes 0.
  - The subBytes instance is purely combinational; its output is captured into buf_data on accept.
- On accept: buf_valid<=1, owner<=granted requester, buf_data<=sbox_out. The result appears on the response port on the cycle after accept (latency 1).
- Response outputs:
  - rnd_rsp_valid = buf_valid AND owner==0; rnd_rsp_data = buf_data.
  - key_rsp_valid = buf_valid AND owner==1; key_rsp_data = buf_data lane KEY_LANE.
  - Data is held stable while valid=1 and ready=0.
- Drain without a new accept: buf_valid<=0. Drain with a new accept: buffer is overwritten, buf_valid stays 1.
- wait_cnt update, in priority order:
  - 0 when key_req_valid=0 or key accepted.
  - Otherwise +1, saturating at 15.
- Boundaries:
  - Buffer full and not draining: both readies 0, counter still advances.
  - Both valid with counter below threshold: rnd wins.
  - Key waits at most MAX_WAIT+1 grant opportunities.
- busy = buf_valid.

Test Plan:
- Reset check: drive rst=1 for 2 cycles with both valids high -> both readies 0, all rsp_valid 0, busy 0. First accept occurs on the cycle after rst falls.
- Round substitution: rnd_req_data=128'h00112233445566778899aabbccddeeff with rnd_rsp_ready=1 -> accepted in cycle N. Cycle N+1 gives rnd_rsp_valid=1 with rnd_rsp_data=128'h638293c31bfc33f5c4eeacea4bc12816.
- Key SubWord, KEY_LANE=0: key_req_data=32'hcf4f3c09 -> key_rsp_data=32'h8a84eb01 one cycle later. Repeat with KEY_LANE=3 -> same result.
- Starvation guard, MAX_WAIT=3: hold rnd and key valid continuously with both rsp_ready=1 -> rnd accepted for 3 cycles, key accepted in the 4th cycle, wait_cnt returns to 0, then rnd resumes.
- Backpressure: rnd result buffered with rnd_rsp_ready=0 for 5 cycles -> data stable, busy=1, both req_ready=0. On the cycle rnd_rsp_ready=1, a pending key request is accepted in the same cycle and key_rsp_valid=1 the next cycle.
- Reset mid-operation: assert rst while a key result is pending (key_rsp_ready=0) -> key_rsp_valid=0 the next cycle and no stale response afterwards.
